// File: rtl/input_debouncer_pkg.sv
// Shared types and limits for the input debouncer.
//   deb_state_t       : debounce FSM state encoding
//   MIN_SYNC_STAGES   : smallest legal synchronizer depth
//   MIN_DEBOUNCE      : smallest legal debounce qualification length
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } deb_state_t;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_DEBOUNCE    = 2;

    function automatic bit params_ok(int unsigned sync_stages, int unsigned debounce_cycles);
        return (sync_stages >= MIN_SYNC_STAGES) && (debounce_cycles >= MIN_DEBOUNCE);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw-input source and the debouncer.
//   raw_in, enable        : driven by the source (master)
//   level, rise, fall, busy : driven by the debouncer (slave)
interface input_debouncer_if;

    logic raw_in;
    logic enable;
    logic level;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output raw_in,
        output enable,
        input  level,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  raw_in,
        input  enable,
        output level,
        output rise,
        output fall,
        output busy
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, loads RESET_VAL into every flop
//   d     : asynchronous input
//   q     : synchronized output (last flop of the chain)
module bit_synchronizer #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for an asynchronous, bouncy input feeding the inverter datapath.
// raw_in is synchronized, then a level change is accepted only after it has
// been seen for DEBOUNCE_CYCLES consecutive clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   dif   : slave side of input_debouncer_if
//           raw_in/enable in; level, rise, fall, busy out
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input_debouncer_if.slave  dif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_check
        $error("input_debouncer: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
    end

    logic s;

    bit_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dif.raw_in),
        .q     (s)
    );

    deb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_q, level_nxt;
    logic             rise_q, rise_nxt;
    logic             fall_q, fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STABLE_LO;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_q <= level_nxt;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (dif.enable && s) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!dif.enable || !s) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (dif.enable && !s) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (!dif.enable || s) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign dif.level = level_q;
    assign dif.rise  = rise_q;
    assign dif.fall  = fall_q;
    assign dif.busy  = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (default parameters).
// Each scenario pushes the expected {level,rise,fall,busy} for every cycle
// into a scoreboard queue as it drives the inputs, then pops and compares
// after the clock edge.
module tb_input_debouncer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [3:0] sb_q[$];
    logic inv_y;

    input_debouncer_if dif ();

    input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    // downstream inverter fed by the debounced level
    assign inv_y = ~dif.level;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] obs_vec();
        return {dif.level, dif.rise, dif.fall, dif.busy};
    endfunction

    function automatic logic [3:0] mk(bit lv, bit r, bit f, bit b);
        return {lv, r, f, b};
    endfunction

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        dif.raw_in = 1'b0;
        dif.enable = 1'b0;
        #1;
        got = obs_vec();
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b required 0000", got);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dif.enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        got = obs_vec();
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required 0000", got);
        end
    endtask

    task automatic test_clean_rise();
        logic [3:0] exp, got;
        for (int c = 1; c <= 8; c++) begin
            dif.raw_in = 1'b1;
            dif.enable = 1'b1;
            sb_q.push_back(mk(c >= 6, c == 6, 1'b0, (c >= 3) && (c <= 5)));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_rise c=%0d: got %b required %b", c, got, exp);
            end
        end
        n_checks++;
        if (inv_y !== 1'b0) begin
            n_fail++;
            $display("FAIL inverter_y: got %b required 0", inv_y);
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] exp, got;
        for (int c = 1; c <= 8; c++) begin
            dif.raw_in = 1'b0;
            sb_q.push_back(mk(c < 6, 1'b0, c == 6, (c >= 3) && (c <= 5)));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clean_fall c=%0d: got %b required %b", c, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp, got;
        for (int len = 2; len <= 4; len++) begin
            for (int c = 1; c <= 12; c++) begin
                dif.raw_in = (c <= len);
                if (len < 4) begin
                    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, (c >= 3) && (c <= len + 2)));
                end else begin
                    // accepted high, then the return to 0 is qualified as a fall
                    sb_q.push_back(mk((c >= 6) && (c <= 9), c == 6, c == 10,
                                      ((c >= 3) && (c <= 5)) || ((c >= 7) && (c <= 9))));
                end
                @(posedge clk);
                #1;
                exp = sb_q.pop_front();
                got = obs_vec();
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL glitch len=%0d c=%0d: got %b required %b", len, c, got, exp);
                end
            end
        end
    endtask

    task automatic test_enable_abort();
        logic [3:0] exp, got;
        for (int c = 1; c <= 10; c++) begin
            dif.raw_in = 1'b1;
            dif.enable = (c != 5);
            sb_q.push_back(mk(c >= 9, c == 9, 1'b0,
                              ((c >= 3) && (c <= 4)) || ((c >= 6) && (c <= 8))));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL enable_abort c=%0d: got %b required %b", c, got, exp);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [3:0] exp, got;
        for (int c = 1; c <= 10; c++) begin
            dif.raw_in = 1'b0;
            dif.enable = 1'b0;
            sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL enable_hold c=%0d: got %b required %b", c, got, exp);
            end
        end
        // s is already low, so qualification starts on the first enabled edge
        for (int c = 1; c <= 6; c++) begin
            dif.enable = 1'b1;
            sb_q.push_back(mk(c < 4, 1'b0, c == 4, c <= 3));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL enable_resume c=%0d: got %b required %b", c, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp, got;
        int rises, falls;
        rises = 0;
        falls = 0;
        for (int c = 1; c <= 20; c++) begin
            dif.raw_in = (c <= 10) ? ((c % 2) == 1) : 1'b1;
            sb_q.push_back(mk(c >= 16, c == 16, 1'b0, 1'b0));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            if (dif.rise === 1'b1) rises++;
            if (dif.fall === 1'b1) falls++;
            n_checks++;
            // busy flickers during the burst; only level and pulses are scored
            if (got[3:1] !== exp[3:1]) begin
                n_fail++;
                $display("FAIL bounce c=%0d: got %b required %b", c, got[3:1], exp[3:1]);
            end
        end
        n_checks++;
        if (rises !== 1 || falls !== 0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got rise=%0d fall=%0d required rise=1 fall=0", rises, falls);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp, got;
        dif.raw_in = 1'b1;
        dif.enable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        got = obs_vec();
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 0000", got);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            sb_q.push_back(mk(c >= 6, c == 6, 1'b0, (c >= 3) && (c <= 5)));
            @(posedge clk);
            #1;
            exp = sb_q.pop_front();
            got = obs_vec();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release c=%0d: got %b required %b", c, got, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_enable_abort();
        test_enable_hold();
        test_bounce();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the inverter datapath.
- Takes an asynchronous, bouncy raw input and synchronizes it into the clk domain.
- Accepts a level change only after it has been stable for DEBOUNCE_CYCLES consecutive clocks.
- Drives the clean level that feeds inverter input a, plus single-cycle rise/fall pulses for downstream sequencing.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on raw_in; legal range is 2 or more.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a change; legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width (localparam, not overridable).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- raw_in  input  1  asynchronous raw input (switch/pin).
- enable  input  1  debounce enable; low freezes the accepted level.
- level  output  1  debounced level; connects to inverter a.
- rise  output  1  one-cycle pulse when level goes 0->1.
- fall  output  1  one-cycle pulse when level goes 1->0.
- busy  output  1  high while a candidate change is being qualified.

Behaviour:
Reset (rst_n low, asynchronous):
- All synchronizer flops = 0.
- state = STABLE_LO, cnt = 0.
- level = 0, rise = 0, fall = 0, busy = 0.

Synchronizer:
- raw_in passes through SYNC_STAGES flops; s is the last flop output.
- The chain runs regardless of enable.

FSM (registered state) and transitions (evaluated each edge, priority top-down):
- STABLE_LO:
  - enable && s: go to CHK_HI, cnt <= 1.
- CHK_HI:
  - !enable: go to STABLE_LO, cnt <= 0.
  - !s: go to STABLE_LO, cnt <= 0 (glitch rejected, no pulse).
  - cnt == DEBOUNCE_CYCLES-1: go to STABLE_HI, level <= 1, rise <= 1, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- STABLE_HI:
  - enable && !s: go to CHK_LO, cnt <= 1.
- CHK_LO:
  - Mirror of CHK_HI with s inverted, target STABLE_LO, level <= 0, fall <= 1.

Outputs and timing:
- rise and fall are registered, high for exactly one cycle, and never high together.
- busy = (state == CHK_HI || state == CHK_LO), decoded from registered state.
- Latency: raw_in stable from before edge 0 gives level updated after edge SYNC_STAGES + DEBOUNCE_CYCLES. Defaults: edge 6.
- Pulses of s shorter than DEBOUNCE_CYCLES cycles never change level.
- A new qualification can start on the cycle after level changes; no dead time is imposed.

Boundary cases:
- enable low: level holds; any in-progress check aborts with cnt = 0 and no pulse.
- enable rising: qualification restarts from cnt = 1 on the first edge where s differs from level.
- Reset mid-check: outputs clear immediately (asynchronous).
- raw_in high across reset release: the chain restarts from 0, so a normal rise occurs after the full latency.
- cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Decomposition:
- Package input_debouncer_pkg:
  - typedef enum logic [1:0] deb_state_t {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO}.
  - Parameter range checks as elaboration-time assertions.
- Sub-module bit_synchronizer (params STAGES, RESET_VAL; ports clk, rst_n, d, q), reusable by other async inputs.
- FSM and counter stay in input_debouncer.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation with raw_in=1 -> level, rise, fall and busy all 0 within the same timestep; after release, rise pulses 6 edges later.
2. Clean rise (defaults): raw_in 0->1 before edge 0, enable=1 -> busy=1 after edge 3; level=1 and rise=1 after edge 6; rise=0 after edge 7; downstream inverter y=0.
3. Glitch reject: raw_in high for 2 cycles then low -> busy pulses, level stays 0, no rise; 3-cycle glitch is also rejected; 4-cycle high is accepted.
4. Clean fall: from level=1, raw_in 1->0 -> level=0 and fall=1 for one cycle 6 edges later; rise stays 0 throughout.
5. Enable abort: raw_in 0->1, enable dropped at the edge where cnt=2 -> busy=0 next cycle, level stays 0; enable back high -> rise after 4 further edges.
6. Bounce burst: raw_in toggles every cycle for 10 cycles then settles at 1 -> exactly one rise pulse, 6 edges after settling; no fall pulse.
